// File: rtl/ifetch_responder_if.sv
// Fetch-side bundle: PC generator handshake, instruction memory port and
// decode-facing FIFO head. The responder takes the slave modport and the
// surrounding logic (or a bench) takes the master modport.
//
// Handshake rules:
//   - The PC generator advances pc_in only in a cycle where stall_pc is 0.
//   - imem_req/imem_addr stay stable from the request until imem_ack;
//     imem_ack completes the single outstanding request.
//   - Decode pops the head in any cycle where instr_valid && instr_ready.
interface ifetch_responder_if;
  logic        go;
  logic [31:0] pc_in;
  logic        branch;
  logic        stall_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_fault;

  modport slave (
    input  go, pc_in, branch, imem_ack, imem_rdata, instr_ready,
    output stall_pc, imem_req, imem_addr, instr_valid, instr_out, instr_pc, instr_fault
  );

  modport master (
    output go, pc_in, branch, imem_ack, imem_rdata, instr_ready,
    input  stall_pc, imem_req, imem_addr, instr_valid, instr_out, instr_pc, instr_fault
  );
endinterface

// File: rtl/ifetch_responder.sv
// Fetch responder: accepts one PC at a time from the PC generator, issues a
// single outstanding instruction-memory request and queues {pc, instr, fault}
// for decode. A branch flushes the queue and discards any in-flight response.
// Misaligned PCs skip memory and enqueue a NOP marked as faulted.
module ifetch_responder #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 reset,
  ifetch_responder_if.slave    fetch_if,
  output logic [1:0]           dbg_state_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   req_pc_q, req_pc_d;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic          fault_mem_q [DEPTH];

  logic          accept;
  logic          aligned;
  logic          push_mis;
  logic          push_mem;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic [31:0]   push_pc;
  logic [31:0]   push_instr;
  logic          push_fault;

  // Accept/push/pop qualifiers; branch blocks every one of them.
  always_comb begin
    fifo_empty = (count_q == '0);
    aligned    = (fetch_if.pc_in[1:0] == 2'b00);
    accept     = fetch_if.go && (state_q == S_IDLE) && (count_q < DEPTH_C) && !fetch_if.branch;
    push_mis   = accept && !aligned;
    push_mem   = (state_q == S_WAIT) && fetch_if.imem_ack && !fetch_if.branch;
    push       = push_mis || push_mem;
    pop        = !fifo_empty && fetch_if.instr_ready && !fetch_if.branch;
    // Only one push source can be active: a misaligned push needs IDLE,
    // a memory push needs WAIT.
    if (push_mis) begin
      push_pc    = fetch_if.pc_in;
      push_instr = NOP_INSN;
      push_fault = 1'b1;
    end else begin
      push_pc    = req_pc_q;
      push_instr = fetch_if.imem_rdata;
      push_fault = 1'b0;
    end
  end

  // Next-state for the request FSM and the latched request PC.
  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    if (accept) begin
      req_pc_d = fetch_if.pc_in;
    end
    case (state_q)
      S_IDLE: begin
        if (accept && aligned) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Ack wins over branch for the state: the request is done either way,
        // branch only decides whether the data is kept (handled by push_mem).
        if (fetch_if.imem_ack) begin
          state_d = S_IDLE;
        end else if (fetch_if.branch) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (fetch_if.imem_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and request PC registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  // FIFO pointer/count update; branch empties the queue outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fetch_if.branch) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO pointer and count registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
        fault_mem_q[i] <= 1'b0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]    <= push_pc;
      instr_mem_q[wr_ptr_q] <= push_instr;
      fault_mem_q[wr_ptr_q] <= push_fault;
    end
  end

  // Output drive: memory port from FSM, head fields forced to 0 when empty.
  always_comb begin
    fetch_if.stall_pc    = !accept;
    fetch_if.imem_req    = (state_q == S_WAIT) || (state_q == S_FLUSH);
    fetch_if.imem_addr   = req_pc_q;
    fetch_if.instr_valid = !fifo_empty;
    fetch_if.instr_out   = '0;
    fetch_if.instr_pc    = '0;
    fetch_if.instr_fault = 1'b0;
    if (!fifo_empty) begin
      fetch_if.instr_out   = instr_mem_q[rd_ptr_q];
      fetch_if.instr_pc    = pc_mem_q[rd_ptr_q];
      fetch_if.instr_fault = fault_mem_q[rd_ptr_q];
    end
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_ifetch_responder.sv
// Directed bench for ifetch_responder: a per-cycle vector table covering
// fetch, back-pressure, branch flush, misaligned PCs and FIFO corner cases,
// followed by a hand-written asynchronous-reset-during-request sequence.
module tb_ifetch_responder;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  ifetch_responder_if fif ();

  ifetch_responder #(
    .DEPTH    (2),
    .NOP_INSN (32'h0000_0013)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_if    (fif.slave),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        go;
    logic        br;
    logic [31:0] pc;
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_stall;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_out;
    logic [31:0] e_ipc;
    logic        e_flt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_fail;

  function automatic void add_vec(
    input logic go, input logic br, input logic [31:0] pc,
    input logic ack, input logic [31:0] rdata, input logic rdy,
    input logic e_stall, input logic e_req, input logic [31:0] e_addr,
    input logic e_valid, input logic [31:0] e_out, input logic [31:0] e_ipc,
    input logic e_flt);
    vec_t v;
    v.go = go; v.br = br; v.pc = pc; v.ack = ack; v.rdata = rdata; v.rdy = rdy;
    v.e_stall = e_stall; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_out = e_out; v.e_ipc = e_ipc; v.e_flt = e_flt;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic go, input logic br, input logic [31:0] pc,
                       input logic ack, input logic [31:0] rdata, input logic rdy);
    fif.go          = go;
    fif.branch      = br;
    fif.pc_in       = pc;
    fif.imem_ack    = ack;
    fif.imem_rdata  = rdata;
    fif.instr_ready = rdy;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " stall_pc"},    {31'b0, fif.stall_pc},    32'd1);
    check({tag, " imem_req"},    {31'b0, fif.imem_req},    32'd0);
    check({tag, " imem_addr"},   fif.imem_addr,            32'd0);
    check({tag, " instr_valid"}, {31'b0, fif.instr_valid}, 32'd0);
    check({tag, " instr_out"},   fif.instr_out,            32'd0);
    check({tag, " instr_pc"},    fif.instr_pc,             32'd0);
    check({tag, " instr_fault"}, {31'b0, fif.instr_fault}, 32'd0);
    check({tag, " state"},       {30'b0, dbg_state},       32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Per-cycle vectors: inputs applied after the falling edge, outputs
    // checked before the next rising edge.
    // fetch PC 0, ack one cycle after request
    add_vec(1,0,32'h000,0,32'h0,       0, 0,0,32'h000,0,32'h0,       32'h000,0);
    add_vec(1,0,32'h004,0,32'h0,       0, 1,1,32'h000,0,32'h0,       32'h000,0);
    add_vec(1,0,32'h004,1,32'hA0000001,0, 1,1,32'h000,0,32'h0,       32'h000,0);
    add_vec(1,0,32'h004,0,32'h0,       1, 0,0,32'h000,1,32'hA0000001,32'h000,0);
    // PCs 4, 8, C with latency 3 and no pops: FIFO fills, stall until pop
    add_vec(1,0,32'h008,0,32'h0,       0, 1,1,32'h004,0,32'h0,       32'h000,0);
    add_vec(1,0,32'h008,0,32'h0,       0, 1,1,32'h004,0,32'h0,       32'h000,0);
    add_vec(1,0,32'h008,1,32'hB0000004,0, 1,1,32'h004,0,32'h0,       32'h000,0);
    add_vec(1,0,32'h008,0,32'h0,       0, 0,0,32'h004,1,32'hB0000004,32'h004,0);
    add_vec(1,0,32'h00C,0,32'h0,       0, 1,1,32'h008,1,32'hB0000004,32'h004,0);
    add_vec(1,0,32'h00C,0,32'h0,       0, 1,1,32'h008,1,32'hB0000004,32'h004,0);
    add_vec(1,0,32'h00C,1,32'hB0000008,0, 1,1,32'h008,1,32'hB0000004,32'h004,0);
    add_vec(1,0,32'h00C,0,32'h0,       0, 1,0,32'h008,1,32'hB0000004,32'h004,0);
    add_vec(1,0,32'h00C,0,32'h0,       1, 1,0,32'h008,1,32'hB0000004,32'h004,0);
    add_vec(1,0,32'h00C,0,32'h0,       0, 0,0,32'h008,1,32'hB0000008,32'h008,0);
    // branch while waiting for PC C; late DEADBEEF must be dropped
    add_vec(1,1,32'h010,0,32'h0,       0, 1,1,32'h00C,1,32'hB0000008,32'h008,0);
    add_vec(1,0,32'h100,0,32'h0,       0, 1,1,32'h00C,0,32'h0,       32'h000,0);
    add_vec(1,0,32'h100,1,32'hDEADBEEF,0, 1,1,32'h00C,0,32'h0,       32'h000,0);
    add_vec(1,0,32'h100,0,32'h0,       1, 0,0,32'h00C,0,32'h0,       32'h000,0);
    add_vec(1,0,32'h104,1,32'hC0000100,0, 1,1,32'h100,0,32'h0,       32'h000,0);
    // branch in the same cycle as ack, then go=0 holds off accepts
    add_vec(1,0,32'h104,0,32'h0,       0, 0,0,32'h100,1,32'hC0000100,32'h100,0);
    add_vec(1,1,32'h108,1,32'hE0000104,0, 1,1,32'h104,1,32'hC0000100,32'h100,0);
    add_vec(0,0,32'h200,0,32'h0,       0, 1,0,32'h104,0,32'h0,       32'h000,0);
    // misaligned PC 6: NOP with fault, no memory request
    add_vec(1,0,32'h006,0,32'h0,       0, 0,0,32'h104,0,32'h0,       32'h000,0);
    add_vec(0,0,32'h008,0,32'h0,       0, 1,0,32'h006,1,32'h13,      32'h006,1);
    add_vec(0,0,32'h008,0,32'h0,       1, 1,0,32'h006,1,32'h13,      32'h006,1);
    add_vec(0,0,32'h008,0,32'h0,       1, 1,0,32'h006,0,32'h0,       32'h000,0);
    // push and pop in the same cycle keep count; ack in IDLE is ignored
    add_vec(1,0,32'h009,0,32'h0,       0, 0,0,32'h006,0,32'h0,       32'h000,0);
    add_vec(1,0,32'h00A,0,32'h0,       1, 0,0,32'h009,1,32'h13,      32'h009,1);
    add_vec(0,0,32'h000,0,32'h0,       0, 1,0,32'h00A,1,32'h13,      32'h00A,1);
    add_vec(0,0,32'h000,0,32'h0,       1, 1,0,32'h00A,1,32'h13,      32'h00A,1);
    add_vec(0,0,32'h000,1,32'hFFFFFFFF,0, 1,0,32'h00A,0,32'h0,       32'h000,0);
    add_vec(0,0,32'h000,0,32'h0,       0, 1,0,32'h00A,0,32'h0,       32'h000,0);

    // reset state
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b1;

    // table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].go, vecs[i].br, vecs[i].pc, vecs[i].ack, vecs[i].rdata, vecs[i].rdy);
      #1;
      check($sformatf("v%0d stall_pc", i),    {31'b0, fif.stall_pc},    {31'b0, vecs[i].e_stall});
      check($sformatf("v%0d imem_req", i),    {31'b0, fif.imem_req},    {31'b0, vecs[i].e_req});
      check($sformatf("v%0d imem_addr", i),   fif.imem_addr,            vecs[i].e_addr);
      check($sformatf("v%0d instr_valid", i), {31'b0, fif.instr_valid}, {31'b0, vecs[i].e_valid});
      check($sformatf("v%0d instr_out", i),   fif.instr_out,            vecs[i].e_out);
      check($sformatf("v%0d instr_pc", i),    fif.instr_pc,             vecs[i].e_ipc);
      check($sformatf("v%0d instr_fault", i), {31'b0, fif.instr_fault}, {31'b0, vecs[i].e_flt});
    end

    // asynchronous reset while a request is outstanding, then a late ack
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h20, 1'b0, 32'h0, 1'b0);
    #1;
    check("rst_seq accept stall_pc", {31'b0, fif.stall_pc}, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h24, 1'b0, 32'h0, 1'b0);
    #1;
    check("rst_seq wait imem_req",  {31'b0, fif.imem_req}, 32'd1);
    check("rst_seq wait imem_addr", fif.imem_addr,         32'h20);
    check("rst_seq wait state",     {30'b0, dbg_state},    32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_seq async");
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h24, 1'b1, 32'h12345678, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_seq late ack imem_req", {31'b0, fif.imem_req}, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h24, 1'b0, 32'h0, 1'b1);
    #1;
    check_reset_outputs("rst_seq after ack");

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
